// File: rtl/bin_counter_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bin_counter_sequencer_pkg
//  Brief    : State encoding shared by the binary counter sequencer.
//  Revision : 1.0
// ============================================================================
package bin_counter_sequencer_pkg;

    localparam int unsigned c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_LOAD = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_UP   = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_DOWN = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_DONE = 3'd4;

endpackage : bin_counter_sequencer_pkg
`default_nettype wire

// File: rtl/bin_counter_sequencer_prescale_tick.sv
`default_nettype none
// ============================================================================
//  Module   : prescale_tick
//  Brief    : Mod-DVSR counter with sync clear and enable; step marks the
//             last count of each period.
//  Revision : 1.0
// ============================================================================
module prescale_tick #(
    parameter int unsigned DVSR   = 50000,
    parameter int unsigned DVSR_W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic step
);

    localparam logic [DVSR_W-1:0] c_LAST = DVSR_W'(DVSR - 1);

    logic [DVSR_W-1:0] r_count;
    logic              w_at_last;

    assign w_at_last = (r_count == c_LAST);
    assign step      = en & w_at_last;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_at_last ? '0 : r_count + DVSR_W'(1);
        end
    end

endmodule : prescale_tick
`default_nettype wire

// File: rtl/bin_counter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : bin_counter_sequencer
//  Brief    : Command-driven sequencer for a universal binary counter with
//             prescaled stepping, single-sweep / ping-pong modes.
//  Revision : 1.0
// ============================================================================
module bin_counter_sequencer
    import bin_counter_sequencer_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned DVSR   = 50000,
    parameter int unsigned DVSR_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         clr_req,
    input  logic         load_req,
    input  logic         dir,
    input  logic         mode,
    input  logic [N-1:0] d_in,
    input  logic         max_tick,
    input  logic         min_tick,
    output logic         syn_clr,
    output logic         load,
    output logic [N-1:0] d,
    output logic         en,
    output logic         up,
    output logic         busy,
    output logic         done_tick
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [N-1:0]         r_d;
    logic                 r_up;
    logic                 r_mode;
    logic                 w_active;
    logic                 w_step;
    logic                 w_bound;

    assign w_active = (r_state == c_ST_UP) || (r_state == c_ST_DOWN);
    assign w_bound  = w_step & ((r_state == c_ST_UP) ? max_tick : min_tick);

    // The prescaler wraps to 0 on the step cycle, so a reversal restarts the
    // period without an explicit clear.
    prescale_tick #(
        .DVSR   (DVSR),
        .DVSR_W (DVSR_W)
    ) u_prescale (
        .clk   (clk),
        .reset (reset),
        .clr   (~w_active),
        .en    (w_active),
        .step  (w_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_d     <= '0;
            r_up    <= 1'b1;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_IDLE && !clr_req) begin
                if (load_req) begin
                    r_d <= d_in;
                end else if (start) begin
                    r_mode <= mode;
                    r_up   <= dir;
                end
            end
            if (w_active && !stop && w_bound && r_mode) begin
                r_up <= ~r_up;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        syn_clr     = 1'b0;
        load        = 1'b0;
        en          = 1'b0;
        busy        = 1'b0;
        done_tick   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (clr_req) begin
                    syn_clr = 1'b1;
                end else if (load_req) begin
                    w_state_nxt = c_ST_LOAD;
                end else if (start) begin
                    w_state_nxt = dir ? c_ST_UP : c_ST_DOWN;
                end
            end
            c_ST_LOAD: begin
                load        = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            c_ST_UP, c_ST_DOWN: begin
                busy = 1'b1;
                if (stop) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_bound) begin
                    if (r_mode) begin
                        w_state_nxt = (r_state == c_ST_UP) ? c_ST_DOWN : c_ST_UP;
                    end else begin
                        w_state_nxt = c_ST_DONE;
                    end
                end else begin
                    en = w_step;
                end
            end
            c_ST_DONE: begin
                done_tick   = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign d  = r_d;
    assign up = r_up;

endmodule : bin_counter_sequencer
`default_nettype wire

// File: tb/tb_bin_counter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin_counter_sequencer
//  Brief    : Directed bench for the sequencer driving a 4-bit counter model.
//  Revision : 1.0
// ============================================================================
module tb_bin_counter_sequencer;

    localparam int unsigned N      = 4;
    localparam int unsigned DVSR   = 4;
    localparam int unsigned DVSR_W = 3;

    typedef struct packed {
        logic         syn_clr;
        logic         load;
        logic         en;
        logic         done_tick;
        logic         up;
        logic         busy;
        logic [N-1:0] d;
        logic [N-1:0] q;
    } ev_t;

    logic         clk = 1'b0;
    logic         reset, cnt_rst;
    logic         start, stop, clr_req, load_req, dir, mode;
    logic [N-1:0] d_in;
    logic         syn_clr, load, en, up, busy, done_tick;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic         max_tick, min_tick;

    int  n_total  = 0;
    int  n_passed = 0;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    bin_counter_sequencer #(
        .N      (N),
        .DVSR   (DVSR),
        .DVSR_W (DVSR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .clr_req   (clr_req),
        .load_req  (load_req),
        .dir       (dir),
        .mode      (mode),
        .d_in      (d_in),
        .max_tick  (max_tick),
        .min_tick  (min_tick),
        .syn_clr   (syn_clr),
        .load      (load),
        .d         (d),
        .en        (en),
        .up        (up),
        .busy      (busy),
        .done_tick (done_tick)
    );

    // Universal counter model with its own reset.
    always_ff @(posedge clk) begin
        if (cnt_rst)      q <= '0;
        else if (syn_clr) q <= '0;
        else if (load)    q <= d;
        else if (en)      q <= up ? q + 4'd1 : q - 4'd1;
    end
    assign max_tick = (q == 4'hF);
    assign min_tick = (q == 4'h0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic ev_t mk_ev(input logic sc, input logic ld, input logic e, input logic dn,
                                  input logic u, input logic b, input logic [N-1:0] dv,
                                  input logic [N-1:0] qv);
        mk_ev = '{syn_clr: sc, load: ld, en: e, done_tick: dn, up: u, busy: b, d: dv, q: qv};
    endfunction

    // Monitor: every visible command strobe must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && (syn_clr || load || en || done_tick)) begin
            ev_t act;
            act = '{syn_clr: syn_clr, load: load, en: en, done_tick: done_tick,
                    up: up, busy: busy, d: d, q: q};
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_event: got %0h expected none", act);
            end else begin
                check("event", 32'(act), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [N-1:0] v, input logic [N-1:0] q_before);
        exp_q.push_back(mk_ev(0, 1, 0, 0, 1, 0, v, q_before));
        load_req = 1'b1;
        d_in     = v;
        tick();
        load_req = 1'b0;
        tick();
        check("load_q", 32'(q), 32'(v));
    endtask

    task automatic do_start(input logic dr, input logic md);
        start = 1'b1;
        dir   = dr;
        mode  = md;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cnt_rst = 1'b1;
        start = 0; stop = 0; clr_req = 0; load_req = 0; dir = 0; mode = 0; d_in = '0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_up",   32'(up),   1);
        check("rst_d",    32'(d),    0);
        check("rst_strobes", 32'({syn_clr, load, en, done_tick}), 0);
        tick();
        reset = 1'b0; cnt_rst = 1'b0;
        tick();

        // Load 0xA.
        do_load(4'hA, 4'h0);

        // Single sweep up from 13: steps at 14,15 then DONE at the bound.
        do_load(4'hD, 4'hA);
        exp_q.push_back(mk_ev(0, 0, 1, 0, 1, 1, 4'hD, 4'd13));
        exp_q.push_back(mk_ev(0, 0, 1, 0, 1, 1, 4'hD, 4'd14));
        exp_q.push_back(mk_ev(0, 0, 0, 1, 1, 0, 4'hD, 4'd15));
        do_start(1'b1, 1'b0);
        repeat (13) tick();
        check("sweep_q",    32'(q),    15);
        check("sweep_busy", 32'(busy), 0);

        // Ping-pong from 14: up to 15, reverse, down to 0, reverse again.
        do_load(4'hE, 4'hF);
        exp_q.push_back(mk_ev(0, 0, 1, 0, 1, 1, 4'hE, 4'd14));
        for (int k = 15; k >= 1; k--) exp_q.push_back(mk_ev(0, 0, 1, 0, 0, 1, 4'hE, 4'(k)));
        do_start(1'b1, 1'b1);
        repeat (72) tick();
        check("pp_up_again", 32'(up),   1);
        check("pp_busy",     32'(busy), 1);
        check("pp_q_nowrap", 32'(q),    0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("pp_stop_busy", 32'(busy), 0);

        // Simultaneous clr/load/start: only the clear is honoured.
        do_load(4'h5, 4'h0);
        exp_q.push_back(mk_ev(1, 0, 0, 0, 1, 0, 4'h5, 4'h5));
        clr_req = 1'b1; load_req = 1'b1; start = 1'b1; dir = 1'b1; d_in = 4'h9;
        tick();
        clr_req = 1'b0; load_req = 1'b0; start = 1'b0;
        check("prio_busy", 32'(busy), 0);
        check("prio_load", 32'(load), 0);
        check("prio_d",    32'(d),    5);
        check("prio_q",    32'(q),    0);

        // Stop coinciding with the first step.
        do_load(4'h7, 4'h0);
        do_start(1'b1, 1'b0);
        repeat (3) tick();
        stop = 1'b1;
        @(negedge clk);
        check("stop_en", 32'(en), 0);
        @(posedge clk); #1;
        stop = 1'b0;
        check("stop_busy", 32'(busy), 0);
        check("stop_q",    32'(q),    7);

        // Reset in the middle of a down sweep.
        do_load(4'h9, 4'h7);
        exp_q.push_back(mk_ev(0, 0, 1, 0, 0, 1, 4'h9, 4'd9));
        exp_q.push_back(mk_ev(0, 0, 1, 0, 0, 1, 4'h9, 4'd8));
        do_start(1'b0, 1'b0);
        repeat (8) tick();
        check("down_up", 32'(up), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_busy", 32'(busy), 0);
        check("mrst_up",   32'(up),   1);
        check("mrst_en",   32'(en),   0);
        check("mrst_d",    32'(d),    0);
        repeat (12) tick();
        check("mrst_q",    32'(q),    7);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule : tb_bin_counter_sequencer
`default_nettype wire
